// File: rtl/pcie_reg_access_ctrl.sv
// Single-DW PCIe register-access sequencer: decodes MWr32/MRd32 request TLPs, runs one
// register-bus transaction at a time and returns a single-beat CplD for every read.
module pcie_reg_access_ctrl #(
    parameter int          ADDR_W       = 16,
    parameter int          ACK_TIMEOUT  = 255,
    parameter logic [15:0] COMPLETER_ID = 16'h0100
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tl_rx_sop,
    input  logic              tl_rx_eop,
    input  logic [31:0]       data_7,
    input  logic [31:0]       data_6,
    input  logic [31:0]       data_5,
    input  logic [31:0]       data_4,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [31:0]       reg_wdata,
    output logic [3:0]        reg_be,
    output logic              reg_wr_en,
    output logic              reg_rd_en,
    input  logic              reg_ack,
    input  logic [31:0]       reg_rdata,
    input  logic              tl_tx_wait,
    output logic              tl_tx_sop,
    output logic              tl_tx_eop,
    output logic              tl_tx_valid,
    output logic [127:0]      tl_tx_data,
    output logic              busy,
    output logic [7:0]        drop_cnt,
    output logic [7:0]        err_cnt
);

    typedef enum logic [1:0] {IDLE, WR_BUS, RD_BUS, CPL_SEND} state_t;

    localparam logic [7:0]  TMO_LAST = 8'(ACK_TIMEOUT - 1);
    localparam logic [31:0] CPL_DW0  = 32'h4A00_0001;

    state_t              r_state, w_state_nxt;
    logic [7:0]          r_wait_cnt;
    logic [15:0]         r_req_id;
    logic [7:0]          r_tag;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [3:0]          r_be;
    logic                r_wr_en, r_rd_en;
    logic                r_tx_vld;
    logic [127:0]        r_tx_data;
    logic [7:0]          r_drop_cnt, r_err_cnt;

    logic                w_req, w_len1;
    logic [7:0]          w_type;
    logic [3:0]          w_be;
    logic                w_go_wr, w_go_rd, w_unsup, w_drop;
    logic                w_bus_ok, w_tmo, w_tx_done;
    logic                w_unused;

    assign w_req    = tl_rx_sop & tl_rx_eop;
    assign w_type   = data_7[31:24];
    assign w_len1   = (data_7[9:0] == 10'd1);
    assign w_be     = data_6[3:0];
    assign w_unused = &{1'b0, data_7[23:10], data_6[7:4], data_5[31:ADDR_W], r_addr[1:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_go_wr     = 1'b0;
        w_go_rd     = 1'b0;
        w_unsup     = 1'b0;
        w_drop      = 1'b0;
        w_bus_ok    = 1'b0;
        w_tmo       = 1'b0;
        w_tx_done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (w_type == 8'h40 && w_len1) begin
                        // zero byte-enable write is a legal no-op
                        if (w_be != 4'h0) begin
                            w_go_wr     = 1'b1;
                            w_state_nxt = WR_BUS;
                        end
                    end else if (w_type == 8'h00 && w_len1) begin
                        w_go_rd     = 1'b1;
                        w_state_nxt = RD_BUS;
                    end else begin
                        w_unsup = 1'b1;
                    end
                end
            end
            WR_BUS, RD_BUS: begin
                w_drop = w_req;
                // an ack on the last allowed cycle wins over the timeout
                if (reg_ack)                      w_bus_ok = 1'b1;
                else if (r_wait_cnt == TMO_LAST)  w_tmo    = 1'b1;
                if (w_bus_ok || w_tmo)
                    w_state_nxt = (r_state == WR_BUS) ? IDLE : CPL_SEND;
            end
            CPL_SEND: begin
                w_drop = w_req;
                if (!tl_tx_wait) begin
                    w_tx_done   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
            r_req_id   <= '0;
            r_tag      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_be       <= '0;
            r_wr_en    <= 1'b0;
            r_rd_en    <= 1'b0;
            r_tx_vld   <= 1'b0;
            r_tx_data  <= '0;
            r_drop_cnt <= '0;
            r_err_cnt  <= '0;
        end else begin
            if (w_go_wr || w_go_rd) begin
                r_addr     <= {data_5[ADDR_W-1:2], 2'b00};
                r_be       <= w_be;
                r_req_id   <= data_6[31:16];
                r_tag      <= data_6[15:8];
                r_wait_cnt <= '0;
            end
            if (w_go_wr) begin
                r_wdata <= data_4;
                r_wr_en <= 1'b1;
            end
            if (w_go_rd) r_rd_en <= 1'b1;
            if ((r_state == WR_BUS || r_state == RD_BUS) && !w_bus_ok && !w_tmo)
                r_wait_cnt <= r_wait_cnt + 8'd1;
            if (w_bus_ok || w_tmo) begin
                r_wr_en <= 1'b0;
                r_rd_en <= 1'b0;
            end
            if (r_state == RD_BUS && (w_bus_ok || w_tmo)) begin
                r_tx_vld  <= 1'b1;
                r_tx_data <= {CPL_DW0,
                              COMPLETER_ID, (w_tmo ? 3'b001 : 3'b000), 1'b0, 12'd4,
                              r_req_id, r_tag, 1'b0, r_addr[6:0],
                              (w_tmo ? 32'hDEAD_BEEF : reg_rdata)};
            end
            if (w_tx_done) begin
                r_tx_vld  <= 1'b0;
                r_tx_data <= '0;
            end
            if (w_drop && r_drop_cnt != 8'hFF)
                r_drop_cnt <= r_drop_cnt + 8'd1;
            if ((w_unsup || w_tmo) && r_err_cnt != 8'hFF)
                r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign reg_addr    = r_addr;
    assign reg_wdata   = r_wdata;
    assign reg_be      = r_be;
    assign reg_wr_en   = r_wr_en;
    assign reg_rd_en   = r_rd_en;
    assign tl_tx_valid = r_tx_vld;
    assign tl_tx_sop   = r_tx_vld;
    assign tl_tx_eop   = r_tx_vld;
    assign tl_tx_data  = r_tx_data;
    assign busy        = (r_state != IDLE);
    assign drop_cnt    = r_drop_cnt;
    assign err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_pcie_reg_access_ctrl.sv
// Bench for pcie_reg_access_ctrl: directed vector table, randomized transactions against a
// transaction-level model, and hand sequences for drops, reset abort and counter saturation.
module tb_pcie_reg_access_ctrl;
    localparam int TMO = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         tl_rx_sop, tl_rx_eop;
    logic [31:0]  data_7, data_6, data_5, data_4;
    logic [15:0]  reg_addr;
    logic [31:0]  reg_wdata;
    logic [3:0]   reg_be;
    logic         reg_wr_en, reg_rd_en, reg_ack;
    logic [31:0]  reg_rdata;
    logic         tl_tx_wait, tl_tx_sop, tl_tx_eop, tl_tx_valid;
    logic [127:0] tl_tx_data;
    logic         busy;
    logic [7:0]   drop_cnt, err_cnt;

    always #5 clk = ~clk;

    pcie_reg_access_ctrl #(.ADDR_W(16), .ACK_TIMEOUT(TMO), .COMPLETER_ID(16'h0100)) dut (
        .clk(clk), .rst_n(rst_n), .tl_rx_sop(tl_rx_sop), .tl_rx_eop(tl_rx_eop),
        .data_7(data_7), .data_6(data_6), .data_5(data_5), .data_4(data_4),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_be(reg_be),
        .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en), .reg_ack(reg_ack), .reg_rdata(reg_rdata),
        .tl_tx_wait(tl_tx_wait), .tl_tx_sop(tl_tx_sop), .tl_tx_eop(tl_tx_eop),
        .tl_tx_valid(tl_tx_valid), .tl_tx_data(tl_tx_data),
        .busy(busy), .drop_cnt(drop_cnt), .err_cnt(err_cnt)
    );

    int nchk = 0;
    int nerr = 0;

    typedef struct {
        logic [7:0]   fmt;
        logic [9:0]   len;
        logic [3:0]   be;
        logic [31:0]  addr;
        logic [31:0]  wdata;
        logic [15:0]  rid;
        logic [7:0]   tag;
        int           ack;
        int           waits;
        logic [31:0]  rdata;
        int           exp_en;
        int           exp_valid;
        logic [127:0] exp_txd;
        logic [15:0]  exp_addr;
        int           exp_err;
    } vec_t;

    typedef struct {
        int           en;
        int           valid;
        int           first_en_c;
        int           last_en_c;
        int           first_v_c;
        logic [127:0] txd;
        logic [15:0]  addr;
        logic [31:0]  wdata;
        logic [3:0]   be;
        logic         stable;
        logic         done;
    } obs_t;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic put_req(input logic [7:0] fmt, input logic [9:0] len, input logic [3:0] be,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [15:0] rid, input logic [7:0] tag);
        tl_rx_sop = 1'b1;
        tl_rx_eop = 1'b1;
        data_7    = {fmt, 14'd0, len};
        data_6    = {rid, tag, 4'h0, be};
        data_5    = addr;
        data_4    = wdata;
    endtask

    task automatic clr_req();
        tl_rx_sop = 1'b0;
        tl_rx_eop = 1'b0;
        data_7    = $urandom;
        data_6    = $urandom;
        data_5    = $urandom;
        data_4    = $urandom;
    endtask

    // Issues one request in IDLE and plays the register bus and tx sink until the block is idle.
    task automatic run_txn(input vec_t v, output obs_t o);
        o = '{0, 0, -1, -1, -1, '0, '0, '0, '0, 1'b1, 1'b0};
        put_req(v.fmt, v.len, v.be, v.addr, v.wdata, v.rid, v.tag);
        @(negedge clk);
        clr_req();
        for (int c = 0; c < 80; c++) begin
            if (!busy) begin
                o.done = 1'b1;
                break;
            end
            if (reg_wr_en || reg_rd_en) begin
                if (o.en == 0) begin
                    o.addr = reg_addr; o.wdata = reg_wdata; o.be = reg_be; o.first_en_c = c;
                end else if (reg_addr !== o.addr || reg_wdata !== o.wdata || reg_be !== o.be) begin
                    o.stable = 1'b0;
                end
                o.en++;
                o.last_en_c = c;
                reg_ack   = (o.en == v.ack);
                reg_rdata = reg_ack ? v.rdata : $urandom;
            end else begin
                reg_ack = 1'b0;
            end
            if (tl_tx_valid) begin
                if (o.valid == 0) begin
                    o.txd = tl_tx_data; o.first_v_c = c;
                end else if (tl_tx_data !== o.txd) begin
                    o.stable = 1'b0;
                end
                o.valid++;
                tl_tx_wait = (o.valid <= v.waits);
            end else begin
                tl_tx_wait = 1'b0;
            end
            @(negedge clk);
        end
        reg_ack    = 1'b0;
        tl_tx_wait = 1'b0;
    endtask

    task automatic check_txn(input string tn, input vec_t v, input obs_t o);
        chk({tn, "_done"},  128'(o.done), 128'(1));
        chk({tn, "_en"},    128'(o.en), 128'(v.exp_en));
        chk({tn, "_valid"}, 128'(o.valid), 128'(v.exp_valid));
        chk({tn, "_err"},   128'(err_cnt), 128'(v.exp_err));
        chk({tn, "_stable"}, 128'(o.stable), 128'(1));
        if (v.exp_en > 0) begin
            chk({tn, "_addr"},   128'(o.addr), 128'(v.exp_addr));
            chk({tn, "_be"},     128'(o.be), 128'(v.be));
            chk({tn, "_en_lat"}, 128'(o.first_en_c), 128'(0));
            if (v.fmt == 8'h40) chk({tn, "_wdata"}, 128'(o.wdata), 128'(v.wdata));
        end
        if (v.exp_valid > 0) begin
            chk({tn, "_txd"},    o.txd, v.exp_txd);
            chk({tn, "_tx_lat"}, 128'(o.first_v_c), 128'(o.last_en_c + 1));
        end
    endtask

    function automatic logic [127:0] cpl(input logic [15:0] rid, input logic [7:0] tag,
                                         input logic [15:0] a, input logic [31:0] rd, input bit tmo);
        logic [2:0] st;
        st = tmo ? 3'b001 : 3'b000;
        return {32'h4A000001, 16'h0100, st, 1'b0, 12'd4, rid, tag, 1'b0, a[6:0],
                (tmo ? 32'hDEADBEEF : rd)};
    endfunction

    vec_t vt[10];
    vec_t rv;
    obs_t ob;
    int   exp_err;
    int   exp_drop;

    initial begin
        vt[0] = '{8'h40, 10'd1, 4'hF, 32'h0000F800, 32'h00000002, 16'h0000, 8'h00, 3, 0, 32'h0,
                  3, 0, 128'h0, 16'hF800, 0};
        vt[1] = '{8'h00, 10'd1, 4'hF, 32'h0000F800, 32'h0, 16'h0000, 8'h04, 1, 0, 32'h00000100,
                  1, 1, 128'h4A000001_01000004_00000400_00000100, 16'hF800, 0};
        vt[2] = '{8'h00, 10'd1, 4'hF, 32'h0000F800, 32'h0, 16'h0000, 8'h04, 1, 5, 32'h00000100,
                  1, 6, 128'h4A000001_01000004_00000400_00000100, 16'hF800, 0};
        vt[3] = '{8'h00, 10'd1, 4'hF, 32'h00000014, 32'h0, 16'h1234, 8'h56, 0, 0, 32'h0,
                  16, 1, 128'h4A000001_01002004_12345614_DEADBEEF, 16'h0014, 1};
        vt[4] = '{8'h40, 10'd1, 4'h0, 32'h00000100, 32'hFFFFFFFF, 16'h0, 8'h0, 1, 0, 32'h0,
                  0, 0, 128'h0, 16'h0, 1};
        vt[5] = '{8'h60, 10'd1, 4'hF, 32'h00000100, 32'h0, 16'h0, 8'h0, 1, 0, 32'h0,
                  0, 0, 128'h0, 16'h0, 2};
        vt[6] = '{8'h00, 10'd2, 4'hF, 32'h00000100, 32'h0, 16'h0, 8'h0, 1, 0, 32'h0,
                  0, 0, 128'h0, 16'h0, 3};
        vt[7] = '{8'h40, 10'd1, 4'h3, 32'h00001237, 32'hA5A5A5A5, 16'h0, 8'h0, 16, 0, 32'h0,
                  16, 0, 128'h0, 16'h1234, 3};
        vt[8] = '{8'h40, 10'd1, 4'h8, 32'h00002000, 32'h12345678, 16'h0, 8'h0, 0, 0, 32'h0,
                  16, 0, 128'h0, 16'h2000, 4};
        vt[9] = '{8'h00, 10'd1, 4'h1, 32'h000000FF, 32'h0, 16'hABCD, 8'hEF, 16, 2, 32'h13579BDF,
                  16, 3, 128'h4A000001_01000004_ABCDEF7C_13579BDF, 16'h00FC, 4};

        rst_n = 1'b0; reg_ack = 1'b0; reg_rdata = '0; tl_tx_wait = 1'b0;
        clr_req();
        repeat (3) @(negedge clk);
        chk("rst_wr_en", 128'(reg_wr_en), 128'(0));
        chk("rst_rd_en", 128'(reg_rd_en), 128'(0));
        chk("rst_addr",  128'(reg_addr), 128'(0));
        chk("rst_tx",    128'({tl_tx_valid, tl_tx_sop, tl_tx_eop}), 128'(0));
        chk("rst_txd",   tl_tx_data, 128'(0));
        chk("rst_busy",  128'(busy), 128'(0));
        chk("rst_cnts",  128'({drop_cnt, err_cnt}), 128'(0));
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_txn(vt[i], ob);
            check_txn($sformatf("vec%0d", i), vt[i], ob);
        end

        // randomized transactions against a transaction-level model
        exp_err = 4;
        for (int i = 0; i < 40; i++) begin
            int k;
            k = $urandom_range(0, 3);
            rv.addr  = $urandom; rv.wdata = $urandom; rv.rid = 16'($urandom); rv.tag = 8'($urandom);
            rv.rdata = $urandom; rv.ack = $urandom_range(1, 20); rv.waits = $urandom_range(0, 3);
            rv.len = 10'd1; rv.be = 4'($urandom_range(1, 15));
            rv.exp_addr = {rv.addr[15:2], 2'b00};
            rv.exp_txd = '0; rv.exp_en = 0; rv.exp_valid = 0;
            case (k)
                0: begin rv.fmt = 8'h40; rv.exp_en = (rv.ack > TMO) ? TMO : rv.ack; end
                1: begin
                    rv.fmt = 8'h00; rv.exp_en = (rv.ack > TMO) ? TMO : rv.ack;
                    rv.exp_valid = rv.waits + 1;
                    rv.exp_txd = cpl(rv.rid, rv.tag, rv.exp_addr, rv.rdata, rv.ack > TMO);
                end
                2: begin rv.fmt = 8'h40; rv.be = 4'h0; end
                default: begin
                    if ($urandom_range(0, 1) == 1) begin
                        rv.fmt = 8'h60;
                    end else begin
                        rv.fmt = ($urandom_range(0, 1) == 1) ? 8'h40 : 8'h00;
                        rv.len = 10'($urandom_range(2, 1023));
                    end
                    exp_err++;
                end
            endcase
            if (k < 2 && rv.ack > TMO) exp_err++;
            rv.exp_err = exp_err;
            run_txn(rv, ob);
            check_txn($sformatf("rnd%0d", i), rv, ob);
        end

        // MWr arriving two cycles into an MRd is dropped, then an unsupported TLP in IDLE
        exp_drop = 0;
        put_req(8'h00, 10'd1, 4'hF, 32'h0000F800, 32'h0, 16'h0, 8'h04);
        @(negedge clk); clr_req();
        @(negedge clk);
        put_req(8'h40, 10'd1, 4'hF, 32'h00000040, 32'h77, 16'h0, 8'h0);
        @(negedge clk); clr_req();
        chk("seq5_rd_en", 128'(reg_rd_en), 128'(1));
        reg_ack = 1'b1; reg_rdata = 32'h00000100;
        @(negedge clk); reg_ack = 1'b0; exp_drop++;
        chk("seq5_tx_valid", 128'(tl_tx_valid), 128'(1));
        chk("seq5_txd", tl_tx_data, 128'h4A000001_01000004_00000400_00000100);
        chk("seq5_drop", 128'(drop_cnt), 128'(exp_drop));
        @(negedge clk);
        chk("seq5_idle", 128'({busy, tl_tx_valid, reg_wr_en}), 128'(0));
        put_req(8'h60, 10'd1, 4'hF, 32'h0, 32'h0, 16'h0, 8'h0);
        @(negedge clk); clr_req(); exp_err++;
        chk("seq5_err", 128'(err_cnt), 128'(exp_err));
        chk("seq5_no_wr", 128'(reg_wr_en), 128'(0));

        // request on the cycle the FSM returns to IDLE is dropped
        put_req(8'h40, 10'd1, 4'hF, 32'h00000010, 32'h1, 16'h0, 8'h0);
        @(negedge clk);
        chk("ret_wr_en", 128'(reg_wr_en), 128'(1));
        reg_ack = 1'b1;
        put_req(8'h40, 10'd1, 4'hF, 32'h00000020, 32'h2, 16'h0, 8'h0);
        @(negedge clk); reg_ack = 1'b0; clr_req(); exp_drop++;
        chk("ret_drop", 128'(drop_cnt), 128'(exp_drop));
        chk("ret_idle", 128'({busy, reg_wr_en}), 128'(0));
        @(negedge clk);
        chk("ret_not_taken", 128'({busy, reg_wr_en}), 128'(0));

        // reset during RD_BUS aborts the read and discards its completion
        put_req(8'h00, 10'd1, 4'hF, 32'h00000080, 32'h0, 16'h0, 8'h09);
        @(negedge clk); clr_req();
        chk("rstmid_rd_en", 128'(reg_rd_en), 128'(1));
        rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        chk("rstmid_outs", 128'({reg_rd_en, reg_wr_en, tl_tx_valid, tl_tx_sop, tl_tx_eop, busy}), 128'(0));
        chk("rstmid_addr", 128'(reg_addr), 128'(0));
        chk("rstmid_cnts", 128'({drop_cnt, err_cnt}), 128'(0));
        @(negedge clk);
        chk("rstmid_no_tx", 128'(tl_tx_valid), 128'(0));
        rv = vt[1];
        rv.exp_err = 0;
        run_txn(rv, ob);
        check_txn("rstmid_next", rv, ob);

        // continuous MRd stream with no acks saturates drop_cnt, then unsupported burst saturates err_cnt
        put_req(8'h00, 10'd1, 4'hF, 32'h00000004, 32'h0, 16'h0, 8'h0);
        repeat (400) @(negedge clk);
        clr_req();
        for (int c = 0; c < 40 && busy; c++) @(negedge clk);
        chk("sat_idle", 128'(busy), 128'(0));
        chk("sat_drop", 128'(drop_cnt), 128'(8'hFF));
        put_req(8'h60, 10'd1, 4'hF, 32'h0, 32'h0, 16'h0, 8'h0);
        repeat (300) @(negedge clk);
        clr_req();
        @(negedge clk);
        chk("sat_err", 128'(err_cnt), 128'(8'hFF));
        chk("sat_drop_hold", 128'(drop_cnt), 128'(8'hFF));

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
